des_sbox_engine: RTL and testbench

- Multi-cycle DES substitution engine; applies all eight standard DES S-boxes (S1..S8) to a 48-bit input and returns a 32-bit result.
- Sits in the round datapath between the E-expansion/key-XOR stage and the round-function output.
- Parametrised lane count trades area for latency: LANES S-box lookups per cycle, 8/LANES cycles per word.
- valid/ready handshake on both sides; result held in a register until consumed.

---
 rtl/des_sbox_engine.sv | 145 ++++++++++++++
 tb/tb_des_sbox_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_sbox_engine.sv
// Multi-cycle DES substitution engine: S1..S8 over a 48-bit word, LANES lookups per cycle.
// Ports: clk, rst (async active-low), in_valid/in_ready/din[47:0], out_valid/out_ready/dout[31:0], busy.
// Option: define DES_SBOX_PERMUTE_EN to apply the DES P-permutation before dout is loaded.
module des_sbox_engine #(
    parameter int LANES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] din,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dout,
    output logic        busy
);

    localparam int GROUPS = 8 / LANES;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    // Each S-box: four 64-bit rows, column 0 in the top nibble of its row.
    localparam logic [0:7][255:0] SBOX = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
        64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
        64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
        64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
        64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
        64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
        64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
        64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
        64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    // Entry index is {row, column} = {c[5], c[0], c[4:1]}.
    function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] c);
        logic [255:0] t;
        t = SBOX[n] << {c[5], c[0], c[4:1], 2'b00};
        return t[255:252];
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    logic [2:0]  grp;
    logic [47:0] din_r;
    logic [31:0] acc;
    logic [31:0] acc_nx;
    logic [31:0] res;
    logic        accept;
    logic        last;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign last     = (grp == 3'(GROUPS - 1));

    // Only the nibbles of the current group are replaced; the rest hold.
    for (genvar n = 0; n < 8; n++) begin : g_pos
        logic sel;
        assign sel = (3'(n / LANES) == grp);
        assign acc_nx[31-4*n -: 4] = sel ? sbox(3'(n), din_r[47-6*n -: 6])
                                         : acc[31-4*n -: 4];
    end

`ifdef DES_SBOX_PERMUTE_EN
    localparam logic [0:31][5:0] PTAB = {
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    // P table numbers bits from 1 at the MSB.
    for (genvar i = 0; i < 32; i++) begin : g_perm
        assign res[31-i] = acc_nx[32-int'(PTAB[i])];
    end
`else
    assign res = acc_nx;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grp       <= '0;
            din_r     <= '0;
            acc       <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        din_r <= din;
                        grp   <= '0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_nx;
                    if (last) begin
                        grp       <= '0;
                        dout      <= res;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        grp <= grp + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            din_r <= din;
                            grp   <= '0;
                            busy  <= 1'b1;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_sbox_engine.sv
// Testbench for des_sbox_engine: four instances (LANES 1, 2, 4, 8) share stimulus.
// Directed vectors, backpressure, in-flight reset and a per-S-box sweep.
module tb_des_sbox_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [47:0] din = '0;
    logic        in_ready  [4];
    logic        out_valid [4];
    logic        busy      [4];
    logic [31:0] dout      [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        des_sbox_engine #(.LANES(1 << k)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready[k]),
            .din      (din),
            .out_valid(out_valid[k]),
            .out_ready(out_ready),
            .dout     (dout[k]),
            .busy     (busy[k])
        );
    end

    int sb [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] golden(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  c;
        int          row;
        int          col;
        r = '0;
        for (int n = 0; n < 8; n++) begin
            c   = d[47-6*n -: 6];
            row = int'(c[5]) * 2 + int'(c[0]);
            col = int'(c[4:1]);
            r[31-4*n -: 4] = 4'(sb[n][row*16+col]);
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_p(input logic [31:0] x);
        int          pt [32];
        logic [31:0] y;
        pt = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
               2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-pt[i]];
        return y;
    endfunction

    function automatic logic [31:0] exp_of(input logic [31:0] raw);
`ifdef DES_SBOX_PERMUTE_EN
        return ref_p(raw);
`else
        return raw;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({out_valid[k], busy[k], in_ready[k], dout[k]} !== {3'b001, 32'h0}) begin
                fails++;
                $display("FAIL reset lanes=%0d got ov=%b busy=%b ir=%b dout=%h exp 0 0 1 0",
                         1 << k, out_valid[k], busy[k], in_ready[k], dout[k]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_word(input string name, input logic [47:0] d, input logic [31:0] e);
        int n;
        in_valid = 1'b1;
        din      = d;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (in_ready[k] !== 1'b1) begin
                fails++;
                $display("FAIL %s idle_ready lanes=%0d got %b exp 1", name, 1 << k, in_ready[k]);
            end
        end
        step();
        in_valid = 1'b0;
        din      = 48'hA5A5_5A5A_C3C3;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            for (int k = 0; k < 4; k++) begin
                n = 8 >> k;
                tests++;
                if ({out_valid[k], busy[k], in_ready[k]} !== {cyc >= n, cyc < n, 1'b0}) begin
                    fails++;
                    $display("FAIL %s timing lanes=%0d cyc=%0d got ov/busy/ir=%b%b%b exp %b%b0",
                             name, 1 << k, cyc, out_valid[k], busy[k], in_ready[k],
                             cyc >= n, cyc < n);
                end
            end
            if (cyc < 8) step();
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (dout[k] !== e) begin
                fails++;
                $display("FAIL %s dout lanes=%0d got %h exp %h", name, 1 << k, dout[k], e);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({out_valid[k], in_ready[k], dout[k]} !== {2'b01, e}) begin
                fails++;
                $display("FAIL %s consume lanes=%0d got ov=%b ir=%b dout=%h exp 0 1 %h",
                         name, 1 << k, out_valid[k], in_ready[k], dout[k], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea;
        logic [31:0] eb;
        ea = exp_of(32'hD9CE3DCB);
`ifdef DES_SBOX_PERMUTE_EN
        eb = 32'h234AA9BB;
`else
        eb = 32'h5C82B597;
`endif
        in_valid = 1'b1;
        din      = 48'hFFFF_FFFF_FFFF;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if ({out_valid[k], in_ready[k], busy[k], dout[k]} !== {3'b100, ea}) begin
                    fails++;
                    $display("FAIL hold lanes=%0d cyc=%0d got ov=%b ir=%b busy=%b dout=%h exp 1 0 0 %h",
                             1 << k, c, out_valid[k], in_ready[k], busy[k], dout[k], ea);
                end
            end
            step();
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din       = 48'h6117_BA86_6527;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (in_ready[k] !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready lanes=%0d got %b exp 1", 1 << k, in_ready[k]);
            end
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({out_valid[k], busy[k]} !== 2'b01) begin
                fails++;
                $display("FAIL b2b_accept lanes=%0d got ov=%b busy=%b exp 0 1",
                         1 << k, out_valid[k], busy[k]);
            end
        end
        repeat (8) step();
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({out_valid[k], dout[k]} !== {1'b1, eb}) begin
                fails++;
                $display("FAIL b2b_dout lanes=%0d got ov=%b dout=%h exp 1 %h",
                         1 << k, out_valid[k], dout[k], eb);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_inflight_reset();
        in_valid = 1'b1;
        din      = 48'h6117_BA86_6527;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        tests++;
        if (busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL midrst_busy lanes=1 got %b exp 1", busy[0]);
        end
        rst = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({out_valid[k], busy[k], in_ready[k], dout[k]} !== {3'b001, 32'h0}) begin
                fails++;
                $display("FAIL midrst lanes=%0d got ov=%b busy=%b ir=%b dout=%h exp 0 0 1 0",
                         1 << k, out_valid[k], busy[k], in_ready[k], dout[k]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                tests++;
                if ({out_valid[k], busy[k], in_ready[k]} !== 3'b001) begin
                    fails++;
                    $display("FAIL postrst lanes=%0d cyc=%0d got ov=%b busy=%b ir=%b exp 0 0 1",
                             1 << k, c, out_valid[k], busy[k], in_ready[k]);
                end
            end
        end
    endtask

    task automatic test_sweep();
        logic [47:0] d;
        logic [31:0] e;
        for (int p = 0; p < 8; p++) begin
            for (int v = 0; v < 64; v++) begin
                d = 48'(v) << (6 * (7 - p));
                e = exp_of(golden(d));
                in_valid = 1'b1;
                din      = d;
                step();
                in_valid = 1'b0;
                repeat (8) step();
                for (int k = 0; k < 4; k++) begin
                    tests++;
                    if ({out_valid[k], dout[k]} !== {1'b1, e}) begin
                        fails++;
                        $display("FAIL sweep lanes=%0d din=%h got ov=%b dout=%h exp 1 %h",
                                 1 << k, d, out_valid[k], dout[k], e);
                    end
                end
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_word("zero", 48'h0, exp_of(32'hEFA72C4D));
        test_word("ones", 48'hFFFF_FFFF_FFFF, exp_of(32'hD9CE3DCB));
`ifdef DES_SBOX_PERMUTE_EN
        test_word("vec", 48'h6117_BA86_6527, 32'h234AA9BB);
`else
        test_word("vec", 48'h6117_BA86_6527, 32'h5C82B597);
`endif
        test_word("s8_1a", 48'h0000_0000_001A, exp_of(32'hEFA72C40));
        test_word("s8_3f", 48'h0000_0000_003F, exp_of(32'hEFA72C4B));
        test_back_to_back();
        test_inflight_reset();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
